// File: rtl/iob_counter.sv
// Wrapping up-counter built on iob_reg_re; increments by one when en_i is high.
module iob_counter #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_nxt;

    assign data_nxt = data_o + DATA_W'(1);

    iob_reg_re #(
        .DATA_W (DATA_W),
        .RST_VAL(RST_VAL)
    ) cnt_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .data_i  (data_nxt),
        .data_o  (data_o)
    );

endmodule

// File: rtl/iob_reg_re.sv
// Register with clock enable, synchronous reset and load enable; async active-low reset.
// Synchronous reset takes priority over the load enable.
module iob_reg_re #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else if (en_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/iob_axis_pack.sv
// Packs DATA_W/TDATA_W narrow AXI-Stream beats into one wide word, lane 0 = first beat = LSBs.
// tlast flushes a partial word; tkeep marks the lanes actually filled.
module iob_axis_pack #(
    parameter int TDATA_W = 8,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       arst_n_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    input  logic [TDATA_W-1:0]         s_axis_tdata_i,
    input  logic                       s_axis_tlast_i,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic [DATA_W-1:0]          m_axis_tdata_o,
    output logic [DATA_W/TDATA_W-1:0]  m_axis_tkeep_o,
    output logic                       m_axis_tlast_o,
    output logic [CNT_W-1:0]           word_count_o
);

    localparam int R      = DATA_W / TDATA_W;
    localparam int LANE_W = (R > 1) ? $clog2(R) : 1;

    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] merged;
    logic [R-1:0]      keep_nxt;

    logic out_free;
    logic completing;
    logic in_hs;
    logic out_hs;
    logic load_out;
    logic valid_en;

    assign out_free   = ~m_axis_tvalid_o | m_axis_tready_i;
    assign completing = (lane == LANE_W'(R - 1)) | s_axis_tlast_i;

    assign s_axis_tready_o = enable_i & (out_free | ~completing);

    assign in_hs    = s_axis_tvalid_i & s_axis_tready_o;
    assign out_hs   = m_axis_tvalid_o & m_axis_tready_i;
    assign load_out = in_hs & completing;
    assign valid_en = load_out | out_hs;

    // Lanes below the current one come from the accumulator, the current lane takes the
    // incoming beat and lanes above are forced to zero so a flushed word is clean.
    for (genvar i = 0; i < R; i++) begin : g_lane
        always_comb begin
            merged[i*TDATA_W +: TDATA_W] = '0;
            if (LANE_W'(i) == lane) begin
                merged[i*TDATA_W +: TDATA_W] = s_axis_tdata_i;
            end else if (LANE_W'(i) < lane) begin
                merged[i*TDATA_W +: TDATA_W] = acc[i*TDATA_W +: TDATA_W];
            end
        end
        assign keep_nxt[i] = (LANE_W'(i) <= lane);
    end

    assign acc_nxt  = completing ? '0 : merged;
    assign lane_nxt = completing ? '0 : lane + LANE_W'(1);

    iob_reg_re #(.DATA_W(LANE_W)) lane_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (in_hs),
        .data_i  (lane_nxt),
        .data_o  (lane)
    );

    iob_reg_re #(.DATA_W(DATA_W)) acc_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (in_hs),
        .data_i  (acc_nxt),
        .data_o  (acc)
    );

    iob_reg_re #(.DATA_W(DATA_W)) data_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (load_out),
        .data_i  (merged),
        .data_o  (m_axis_tdata_o)
    );

    iob_reg_re #(.DATA_W(R)) keep_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (load_out),
        .data_i  (keep_nxt),
        .data_o  (m_axis_tkeep_o)
    );

    iob_reg_re #(.DATA_W(1)) last_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (load_out),
        .data_i  (s_axis_tlast_i),
        .data_o  (m_axis_tlast_o)
    );

    // A completion in the same cycle as a sink accept reloads and keeps valid high.
    iob_reg_re #(.DATA_W(1)) valid_reg (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (valid_en),
        .data_i  (load_out),
        .data_o  (m_axis_tvalid_o)
    );

    iob_counter #(.DATA_W(CNT_W)) word_cnt (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .en_i    (out_hs),
        .data_o  (word_count_o)
    );

endmodule

// File: tb/tb_iob_axis_pack.sv
// Directed and random checks of iob_axis_pack (8-bit beats into 32-bit words)
// against an independent packing scoreboard.
module tb_iob_axis_pack;

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst_n = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [31:0] word_count;

    int n_chk = 0;
    int n_bad = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_keep_q[$];
    logic        exp_last_q[$];
    logic [31:0] mdl_acc = '0;
    int          mdl_lane = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;

    iob_axis_pack #(.TDATA_W(8), .DATA_W(32), .CNT_W(32)) dut (
        .clk_i          (clk),
        .cke_i          (cke),
        .arst_n_i       (arst_n),
        .rst_i          (rst),
        .enable_i       (enable),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .s_axis_tdata_i (s_tdata),
        .s_axis_tlast_i (s_tlast),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .m_axis_tdata_o (m_tdata),
        .m_axis_tkeep_o (m_tkeep),
        .m_axis_tlast_o (m_tlast),
        .word_count_o   (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are stable between the negedge and the next posedge, so handshakes seen here
    // are exactly the ones the DUT takes on the coming edge.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stable_valid", m_tvalid, 1'b1);
            chk("stable_data", m_tdata, prev_data);
            chk("stable_keep", m_tkeep, prev_keep);
            chk("stable_last", m_tlast, prev_last);
        end
        if (rst || !arst_n) begin
            exp_data_q.delete();
            exp_keep_q.delete();
            exp_last_q.delete();
            mdl_acc = '0;
            mdl_lane = 0;
            out_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            prev_stall = m_tvalid & ~m_tready;
            prev_data = m_tdata;
            prev_keep = m_tkeep;
            prev_last = m_tlast;
            if (m_tvalid && m_tready) begin
                out_cnt++;
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_word", m_tdata, 32'hx);
                end else begin
                    chk("sb_data", m_tdata, exp_data_q.pop_front());
                    chk("sb_keep", m_tkeep, exp_keep_q.pop_front());
                    chk("sb_last", m_tlast, exp_last_q.pop_front());
                end
            end
            if (s_tvalid && s_tready) begin
                in_cnt++;
                mdl_acc[mdl_lane*8 +: 8] = s_tdata;
                if (s_tlast || mdl_lane == 3) begin
                    exp_data_q.push_back(mdl_acc);
                    exp_keep_q.push_back(4'((1 << (mdl_lane + 1)) - 1));
                    exp_last_q.push_back(s_tlast);
                    mdl_acc = '0;
                    mdl_lane = 0;
                end else begin
                    mdl_lane++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int budget;
        s_tvalid = 1'b1;
        s_tdata = d;
        s_tlast = l;
        budget = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            budget++;
            if (budget > 2000) begin
                chk("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic soft_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while ((exp_data_q.size() != 0 || m_tvalid) && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk(tag, exp_data_q.size(), 0);
    endtask

    initial begin
        bit running;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m_tvalid, 1'b0);
        chk("rst_data", m_tdata, 32'h0);
        chk("rst_keep", m_tkeep, 4'h0);
        chk("rst_count", word_count, 32'h0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tready", s_tready, 1'b1);

        // 1: full word, one cycle latency
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("t1_not_yet", m_tvalid, 1'b0);
        send(8'h44, 1'b1);
        chk("t1_valid", m_tvalid, 1'b1);
        chk("t1_data", m_tdata, 32'h44332211);
        chk("t1_keep", m_tkeep, 4'b1111);
        chk("t1_last", m_tlast, 1'b1);

        // 2: partial word flushed by tlast, next beat in lane 0, tlast at lane 0
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        chk("t2_data", m_tdata, 32'h00CCBBAA);
        chk("t2_keep", m_tkeep, 4'b0111);
        chk("t2_last", m_tlast, 1'b1);
        send(8'hDD, 1'b1);
        chk("t2_lane0_data", m_tdata, 32'h000000DD);
        chk("t2_lane0_keep", m_tkeep, 4'b0001);
        drain("t2_drain");
        chk("t2_count", word_count, 32'd3);

        // 3: sink stalled across 8 continuous beats
        soft_reset();
        chk("t3_count_clr", word_count, 32'd0);
        in_cnt = 0;
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("t3_accepted", in_cnt, 7);
                chk("t3_stall_tready", s_tready, 1'b0);
                chk("t3_stall_valid", m_tvalid, 1'b1);
                chk("t3_stall_data", m_tdata, 32'h13121110);
                m_tready = 1'b1;
            end
        join
        drain("t3_drain");
        chk("t3_count", word_count, 32'd2);

        // 4: enable dropped mid-frame
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        enable = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'h03;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_disabled_tready", s_tready, 1'b0);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("t4_data", m_tdata, 32'h04030201);
        chk("t4_keep", m_tkeep, 4'b1111);
        chk("t4_last", m_tlast, 1'b0);
        drain("t4_drain");

        // 5: soft reset with a pending word and a partial accumulation
        m_tready = 1'b0;
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        send(8'h54, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        chk("t5_pending", m_tvalid, 1'b1);
        soft_reset();
        chk("t5_valid_clr", m_tvalid, 1'b0);
        chk("t5_count_clr", word_count, 32'd0);
        m_tready = 1'b1;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        chk("t5_clean_data", m_tdata, 32'hA4A3A2A1);
        chk("t5_clean_keep", m_tkeep, 4'b1111);
        drain("t5_drain");

        // 6: random traffic against the scoreboard
        soft_reset();
        running = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
                end
                send(8'hEE, 1'b1);
                running = 1'b0;
            end
            begin
                while (running) begin
                    @(posedge clk);
                    #1;
                    m_tready = ($urandom_range(0, 1) == 1);
                end
                m_tready = 1'b1;
            end
        join
        drain("t6_drain");
        chk("t6_count", word_count, 32'(out_cnt));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
